// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush/freeze sequencing for the 5-stage core.
// Optional HAZARD_PERF_EN adds Stall_Cycles / Flush_Cycles performance counters.
module hazard_control_unit #(
  parameter int FLUSH_DEPTH = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_RS1,
  input  logic [4:0]  IF_ID_RS2,
  input  logic        IF_ID_UsesRS1,
  input  logic        IF_ID_UsesRS2,
  input  logic [4:0]  ID_EX_RD,
  input  logic        ID_EX_MemRead,
  input  logic        EX_Redirect,
  input  logic        DMEM_Req,
  input  logic        DMEM_Ready,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        ID_EX_Hold,
  output logic        EX_MEM_Hold,
  output logic        MEM_WB_Bubble,
`ifdef HAZARD_PERF_EN
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Cycles,
`endif
  output logic        MEM_Timeout
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);
  localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);
  localparam logic       TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic       MULTI_FLUSH  = (FLUSH_DEPTH > 1);

  logic [1:0] state, state_n;
  logic [1:0] flush_cnt, flush_cnt_n;
  logic [7:0] wait_cnt, wait_cnt_n;

  logic load_use_hit;
  logic timeout_hit;
  logic mem_stall;

  always_comb begin
    load_use_hit = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                   ((IF_ID_UsesRS1 && (ID_EX_RD == IF_ID_RS1)) ||
                    (IF_ID_UsesRS2 && (ID_EX_RD == IF_ID_RS2)));
    timeout_hit  = TIMEOUT_EN && (state == MEM_WAIT) &&
                   (wait_cnt == TIMEOUT_VAL) && !DMEM_Ready;
    // An expiring wait wins over a still-pending request so the pipe can move on.
    mem_stall    = DMEM_Req && !DMEM_Ready && !timeout_hit;
  end

  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Hold   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    MEM_Timeout   = 1'b0;
    state_n       = state;
    flush_cnt_n   = flush_cnt;
    wait_cnt_n    = wait_cnt;

    if (mem_stall) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Hold    = 1'b1;
      EX_MEM_Hold   = 1'b1;
      MEM_WB_Bubble = 1'b1;
      state_n       = MEM_WAIT;
      wait_cnt_n    = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end else begin
      state_n    = RUN;
      wait_cnt_n = 8'd0;
      if (timeout_hit) begin
        MEM_Timeout   = 1'b1;
        MEM_WB_Bubble = 1'b1;
      end
      if (EX_Redirect) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        if (MULTI_FLUSH) begin
          state_n     = FLUSH;
          flush_cnt_n = FLUSH_RELOAD;
        end else begin
          flush_cnt_n = 2'd0;
        end
      end else if (state == FLUSH) begin
        // Wrong-path fetches still arriving from a registered IMEM; no load-use here.
        IF_ID_Flush = 1'b1;
        flush_cnt_n = flush_cnt - 2'd1;
        state_n     = (flush_cnt <= 2'd1) ? RUN : FLUSH;
      end else if (load_use_hit) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end

    if (!rst_n) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      ID_EX_Hold    = 1'b0;
      EX_MEM_Hold   = 1'b0;
      MEM_WB_Bubble = 1'b1;
      MEM_Timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
      wait_cnt  <= 8'd0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      wait_cnt  <= wait_cnt_n;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Stall_Cycles <= 32'd0;
      Flush_Cycles <= 32'd0;
    end else begin
      if (!PC_Write)   Stall_Cycles <= Stall_Cycles + 32'd1;
      if (IF_ID_Flush) Flush_Cycles <= Flush_Cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit (FLUSH_DEPTH=2, MEM_TIMEOUT=4).
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, redir, req, rdy;
  logic       pc_w, ifid_w, ifid_f, idex_b, idex_h, exmem_h, memwb_b, mto;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.FLUSH_DEPTH(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RS1(rs1), .IF_ID_RS2(rs2),
    .IF_ID_UsesRS1(u1), .IF_ID_UsesRS2(u2),
    .ID_EX_RD(rd), .ID_EX_MemRead(mr),
    .EX_Redirect(redir), .DMEM_Req(req), .DMEM_Ready(rdy),
    .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f),
    .ID_EX_Bubble(idex_b), .ID_EX_Hold(idex_h), .EX_MEM_Hold(exmem_h),
    .MEM_WB_Bubble(memwb_b),
`ifdef HAZARD_PERF_EN
    .Stall_Cycles(stall_cycles), .Flush_Cycles(flush_cycles),
`endif
    .MEM_Timeout(mto)
  );

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold, MEM_WB_Bubble, MEM_Timeout}
  localparam logic [7:0] E_DEF   = 8'b1100_0000;
  localparam logic [7:0] E_LU    = 8'b0001_0000;
  localparam logic [7:0] E_REDIR = 8'b1111_0000;
  localparam logic [7:0] E_FLUSH = 8'b1110_0000;
  localparam logic [7:0] E_FRZ   = 8'b0000_1110;
  localparam logic [7:0] E_RST   = 8'b0011_0010;
  localparam logic [7:0] E_TO    = 8'b1100_0011;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Inputs change 1ns after posedge; outputs are checked on the following negedge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb.pop_front();
      act = {pc_w, ifid_w, ifid_f, idex_b, idex_h, exmem_h, memwb_b, mto};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic cyc(input logic rn, input logic m, input logic [4:0] d,
                     input logic [4:0] s1, input logic a1, input logic [4:0] s2, input logic a2,
                     input logic r, input logic q, input logic y,
                     input logic [7:0] exp, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; mr = m; rd = d; rs1 = s1; u1 = a1; rs2 = s2; u2 = a2;
    redir = r; req = q; rdy = y;
    e.exp = exp;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [7:0] exp, input string nm);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp, nm);
  endtask

  initial begin
    rst_n = 1'b0; mr = 1'b0; rd = '0; rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0;
    redir = 1'b0; req = 1'b0; rdy = 1'b0;

    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "reset_0");
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "reset_1");
    idle(E_DEF, "run_default");

    // load-use via RS2, then via RS1, and the non-stalling cases
    cyc(1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU, "loaduse_rs2");
    idle(E_DEF, "loaduse_after");
    cyc(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_DEF, "x0_no_stall");
    cyc(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, E_DEF, "unused_rs1");
    cyc(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, "loaduse_rs1");
    cyc(1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "no_load");

    // redirect with two-cycle flush
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_REDIR, "redir_c0");
    idle(E_FLUSH, "redir_c1");
    idle(E_DEF, "redir_done");

    // redirect beats load-use in the same cycle, and load-use is ignored during FLUSH
    cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_REDIR, "redir_lu");
    cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_FLUSH, "lu_in_flush");
    idle(E_DEF, "redir_lu_done");

    // redirect inside FLUSH reloads the counter
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_REDIR, "reload_c0");
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_REDIR, "reload_c1");
    idle(E_FLUSH, "reload_c2");
    idle(E_DEF, "reload_done");

    // memory wait with a pending redirect acted on in the ready cycle
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FRZ, $sformatf("memwait_%0d", i));
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_REDIR, "memwait_ready");
    idle(E_FLUSH, "memwait_flush");
    idle(E_DEF, "memwait_done");

    // timeout after four wait cycles
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, $sformatf("to_wait_%0d", i));
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_TO, "timeout_pulse");
    idle(E_DEF, "timeout_after");

    // reset mid-FLUSH aborts the remaining flush cycle
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_REDIR, "rflush_redir");
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "rflush_reset");
    idle(E_DEF, "rflush_after");

    // reset mid-MEM_WAIT clears the wait counter
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, "rwait_0");
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, "rwait_1");
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RST, "rwait_reset");
    idle(E_DEF, "rwait_after");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, $sformatf("rwait_re_%0d", i));
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_TO, "rwait_timeout");
    idle(E_DEF, "final_default");

`ifdef HAZARD_PERF_EN
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "perf_reset");
    @(posedge clk);
    #1;
    checks++;
    if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      failures++;
      $display("FAIL perf_clear: got stall=%0d flush=%0d expected 0 0", stall_cycles, flush_cycles);
    end
`endif

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core, companion to the EX-stage operand forwarding logic.
- Resolves hazards that forwarding cannot cover: load-use stall, branch/jump redirect flush (multi-cycle for registered IMEM), and whole-pipe freeze on data-memory wait.
- Drives the PC write enable plus the per-stage write/flush/hold controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- FLUSH_DEPTH, 1, cycles IF/ID is squashed after a redirect (1 = combinational IMEM; 2 = registered IMEM); legal 1..4.
- MEM_TIMEOUT, 255, max consecutive data-memory wait cycles before abort; 8-bit counter; 0 disables timeout.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- IF_ID_RS1, IF_ID_RS2  in  5 each  source registers of the instruction in decode
- IF_ID_UsesRS1, IF_ID_UsesRS2  in  1 each  decode instruction actually reads RS1/RS2
- ID_EX_RD  in  5  destination of the instruction in EX
- ID_EX_MemRead  in  1  EX instruction is a load
- EX_Redirect  in  1  taken branch / JAL / JALR resolved in EX this cycle
- DMEM_Req  in  1  MEM stage has an access in flight
- DMEM_Ready  in  1  data memory completes this cycle
- PC_Write  out  1  PC register enable
- IF_ID_Write  out  1  IF/ID enable
- IF_ID_Flush  out  1  IF/ID loads NOP
- ID_EX_Bubble  out  1  ID/EX loads NOP (control zeroed)
- ID_EX_Hold, EX_MEM_Hold  out  1 each  stage register keeps its value
- MEM_WB_Bubble  out  1  MEM/WB loads NOP
- MEM_Timeout  out  1  one-cycle pulse, wait aborted

Behaviour:
- Registered state: RUN, FLUSH, MEM_WAIT; 2-bit flush counter; 8-bit wait counter. Outputs combinational from state + inputs.
- rst_n low at a clock edge: state<=RUN, counters<=0. While rst_n low, outputs forced: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, MEM_WB_Bubble=1, holds=0, MEM_Timeout=0. Reset mid-FLUSH/MEM_WAIT aborts immediately.
- Default (RUN, no event): PC_Write=1, IF_ID_Write=1, all flush/bubble/hold/timeout=0.
- Priority per cycle: memory wait > redirect > load-use.
- Memory wait: DMEM_Req=1 & DMEM_Ready=0 in any state -> same cycle PC_Write=0, IF_ID_Write=0, ID_EX_Hold=1, EX_MEM_Hold=1, MEM_WB_Bubble=1; next state MEM_WAIT, wait counter increments. EX_Redirect and load-use ignored while frozen (inputs stay stable because stages are held).
- MEM_WAIT exit: DMEM_Ready=1 -> that cycle behaves as RUN (redirect/load-use evaluated normally), counter cleared. If counter reaches MEM_TIMEOUT (nonzero) with Ready still 0: MEM_Timeout=1 that cycle, MEM_WB_Bubble=1, holds released, return to RUN.
- Redirect (EX_Redirect=1, not frozen): PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1 same cycle. If FLUSH_DEPTH>1: next state FLUSH, counter=FLUSH_DEPTH-1; in FLUSH, IF_ID_Flush=1, PC_Write=1, counter decrements, return to RUN at 0. New redirect in FLUSH reloads counter. Redirect suppresses load-use stall in the same cycle.
- Load-use: ID_EX_MemRead=1 & ID_EX_RD!=0 & ((UsesRS1 & RD==RS1) | (UsesRS2 & RD==RS2)), in RUN only -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly one cycle; state stays RUN (bubble clears condition). x0 never stalls.
- No output depends on undefined inputs; outputs never X after first reset edge.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs Stall_Cycles and Flush_Cycles (32-bit each), incrementing on each cycle with PC_Write=0 and IF_ID_Flush=1 respectively (not during reset), wrap at 2^32-1 -> 0, cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RD=5, IF_ID_RS2=5, UsesRS2=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle (MemRead=0) all default.
- x0/unused: ID_EX_RD=0 = RS1, or RD=7 = RS1 with UsesRS1=0 -> no stall.
- Redirect, FLUSH_DEPTH=2: EX_Redirect pulse -> IF_ID_Flush=1 for 2 cycles, ID_EX_Bubble=1 first cycle only, PC_Write=1 throughout; redirect+load-use same cycle -> no stall.
- Memory wait: DMEM_Req=1, Ready low 3 cycles -> 3 frozen cycles (holds=1, MEM_WB_Bubble=1), EX_Redirect held high is acted on in the Ready cycle.
- Timeout, MEM_TIMEOUT=4: Ready never asserted -> MEM_Timeout pulse exactly once after 4 wait cycles, then RUN.
- Reset: rst_n low mid-FLUSH and mid-MEM_WAIT -> reset output values next cycle, RUN defaults after release; with HAZARD_PERF_EN counters read 0.
